// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the RV64I front end.
// Fetch state encodings are plain 2-bit constants so older netlists that compare raw codes keep working.
package pipeline_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int INST_WIDTH = 32;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef enum logic [1:0] {
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        DROP = ST_DROP,
        HALT = ST_HALT
    } fetch_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] instr;
        logic                  err;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions feeding decode.
// Flush wins over any enqueue/dequeue in the same cycle.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    enq_valid,
    input  fetch_entry_t            enq_entry,
    input  logic                    deq_ready,
    output fetch_entry_t            head_entry,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t    mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            enq_fire;
    logic            deq_fire;

    always_comb begin
        full       = (count_reg == CW'(DEPTH));
        empty      = (count_reg == '0);
        count      = count_reg;
        enq_fire   = enq_valid && !full && !flush;
        deq_fire   = deq_ready && !empty && !flush;
        // Present zeros while empty so the decode-facing outputs are clean after reset or flush.
        head_entry = empty ? '0 : mem_reg[rd_ptr_reg];
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem_reg[wr_ptr_reg] <= enq_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(enq_fire) - CW'(deq_fire);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the fetch PC, keeps one imem request in flight and
// buffers returned instructions for decode; redirects flush everything and restart.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = 64'h8000_0000,
    parameter int                    QUEUE_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_pc,
    output logic [INST_WIDTH-1:0] id_instr,
    output logic                  id_fetch_error
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_e          state_reg;
    fetch_state_e          state_next;
    logic [DATA_WIDTH-1:0] fetch_pc_reg;
    logic [DATA_WIDTH-1:0] fetch_pc_next;

    logic                  misaligned;
    logic                  enq_valid;
    fetch_entry_t          enq_entry;
    fetch_entry_t          head_entry;
    logic                  q_full;
    logic                  q_empty;
    logic [CW-1:0]         q_count;
    logic [CW-1:0]         occupancy;
    logic                  space_ok;
    logic                  req_fire;

    always_comb begin
        misaligned = (fetch_pc_reg[1:0] != 2'b00);
        enq_valid  = 1'b0;
        enq_entry  = '0;
        if (state_reg == REQ && misaligned && !q_full) begin
            enq_valid = 1'b1;
            enq_entry = '{pc: fetch_pc_reg, instr: NOP_INST, err: 1'b1};
        end else if (state_reg == WAIT && imem_rsp_valid) begin
            // fetch_pc has already advanced past the outstanding request.
            enq_valid = 1'b1;
            enq_entry = '{pc:    fetch_pc_reg - DATA_WIDTH'(4),
                          instr: imem_rsp_err ? NOP_INST : imem_rsp_data,
                          err:   imem_rsp_err};
        end

        // This cycle's dequeue is deliberately not credited, keeping the path off id_ready.
        occupancy = q_count + CW'(enq_valid);
        space_ok  = (occupancy < CW'(QUEUE_DEPTH));

        imem_req_valid = rst_n && !redirect_valid && space_ok &&
                         ((state_reg == REQ && !misaligned) ||
                          (state_reg == WAIT && imem_rsp_valid && !imem_rsp_err));
        imem_req_addr  = fetch_pc_reg;
        req_fire       = imem_req_valid && imem_req_ready;
    end

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid) begin
            fetch_pc_next = redirect_pc;
            state_next    = ((state_reg == WAIT || state_reg == DROP) && !imem_rsp_valid) ? DROP : REQ;
        end else begin
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + DATA_WIDTH'(4);
            end
            case (state_reg)
                REQ: begin
                    if (misaligned) begin
                        if (!q_full) begin
                            state_next = HALT;
                        end
                    end else if (req_fire) begin
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            state_next = HALT;
                        end else if (!req_fire) begin
                            state_next = REQ;
                        end
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_next = REQ;
                    end
                end
                HALT:    state_next = HALT;
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= REQ;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .enq_valid (enq_valid),
        .enq_entry (enq_entry),
        .deq_ready (id_ready),
        .head_entry(head_entry),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_comb begin
        id_valid       = !q_empty;
        id_pc          = head_entry.pc;
        id_instr       = head_entry.instr;
        id_fetch_error = head_entry.err;
    end

endmodule
